// File: rtl/ecc_pkg.sv
// Shared constants, encodings and helpers for the ECC lane-serial front end.
package ecc_pkg;

    localparam int MAX_BITS = 128;
    localparam int NUM_OPS  = 6;
    localparam int OP_PX    = 3;
    localparam int OP_PY    = 4;

    typedef enum logic [1:0] {
        BITS16  = 2'b00,
        BITS32  = 2'b01,
        BITS64  = 2'b10,
        BITS128 = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        MODE1,
        MODE0,
        LOAD,
        START,
        WAIT_CORE,
        SEND
    } state_e;

    function automatic int width_of(input logic [1:0] mode);
        return 16 << mode;
    endfunction

    function automatic int beats(input logic [1:0] mode, input int lanes);
        return width_of(mode) / lanes;
    endfunction

endpackage

// File: rtl/ecc_lane_shifter.sv
// MAX_BITS-wide shift register: clear, LANES-wide shift-in at the LSB end,
// and parallel load. The serial output is taken from the top LANES bits.
module ecc_lane_shifter #(
    parameter int WIDTH = 128,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [LANES-1:0] lane_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (load_en)
            q <= load_val;
        else if (shift_en)
            q <= {q[WIDTH-LANES-1:0], lane_in};
    end

endmodule

// File: rtl/ecc_lane_port.sv
// Lane-serial command/result front end for the ECC point-multiplication core:
// deserialises mode plus six operands, starts the core, serialises Rx/Ry back out.
module ecc_lane_port #(
    parameter int MAX_BITS = 128,
    parameter int LANES    = 1,
    parameter int BEATW    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_data_valid,
    input  logic                i_cmd,
    input  logic                i_mode,
    input  logic [LANES-1:0]    i_a,
    input  logic [LANES-1:0]    i_b,
    input  logic [LANES-1:0]    i_prime,
    input  logic [LANES-1:0]    i_Px,
    input  logic [LANES-1:0]    i_Py,
    input  logic [LANES-1:0]    i_m,
    input  logic                i_out_ready,
    output logic                o_data_valid,
    output logic [LANES-1:0]    o_Px,
    output logic [LANES-1:0]    o_Py,
    output logic                o_busy,
    output logic                o_cmd_err,
    output logic                o_core_start,
    output logic [1:0]          o_core_mode,
    output logic [MAX_BITS-1:0] o_core_a,
    output logic [MAX_BITS-1:0] o_core_b,
    output logic [MAX_BITS-1:0] o_core_prime,
    output logic [MAX_BITS-1:0] o_core_Px,
    output logic [MAX_BITS-1:0] o_core_Py,
    output logic [MAX_BITS-1:0] o_core_m,
    input  logic                i_core_done,
    input  logic [MAX_BITS-1:0] i_core_Rx,
    input  logic [MAX_BITS-1:0] i_core_Ry
);
    import ecc_pkg::*;

    state_e state_q, state_d;
    mode_e  mode_q;
    logic [BEATW-1:0] beat_q, last_beat;
    logic loaded_q, reload_q, cmd_err_q;
    logic strobe, reload_ok, retire, core_accept, unused_res;
    logic [7:0] align_sh;

    logic [NUM_OPS-1:0][LANES-1:0]    op_lane;
    logic [NUM_OPS-1:0][MAX_BITS-1:0] op_q;
    logic [1:0][MAX_BITS-1:0]         res_q, res_aligned;

    assign strobe      = (state_q == IDLE) && i_data_valid;
    assign reload_ok   = strobe && i_cmd && loaded_q;
    assign retire      = (state_q == SEND) && i_out_ready;
    assign core_accept = (state_q == WAIT_CORE) && i_core_done;
    assign last_beat   = BEATW'(beats(mode_q, LANES) - 1);

    // Results are pre-shifted so bit W-1 sits at the top and leaves first.
    assign align_sh       = 8'(MAX_BITS - width_of(mode_q));
    assign res_aligned[0] = i_core_Rx << align_sh;
    assign res_aligned[1] = i_core_Ry << align_sh;

    assign op_lane = {i_m, i_Py, i_Px, i_prime, i_b, i_a};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        localparam bit IS_POINT = (g == OP_PX) || (g == OP_PY);
        ecc_lane_shifter #(.WIDTH(MAX_BITS), .LANES(LANES)) u_sh (
            .clk      (clk),
            .rst      (rst),
            .clr      ((state_q == MODE0) || (IS_POINT && reload_ok)),
            .shift_en ((state_q == LOAD) && (IS_POINT || !reload_q)),
            .load_en  (1'b0),
            .lane_in  (op_lane[g]),
            .load_val ('0),
            .q        (op_q[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_res
        ecc_lane_shifter #(.WIDTH(MAX_BITS), .LANES(LANES)) u_sh (
            .clk      (clk),
            .rst      (rst),
            .clr      (1'b0),
            .shift_en (retire),
            .load_en  (core_accept),
            .lane_in  ('0),
            .load_val (res_aligned[g]),
            .q        (res_q[g])
        );
    end

    // Only the leading lane of each result register is observed.
    assign unused_res = ^{res_q[0][MAX_BITS-LANES-1:0], res_q[1][MAX_BITS-LANES-1:0]};

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_busy       = (state_q != IDLE);
        o_core_start = 1'b0;
        o_data_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe && !i_cmd)
                    state_d = MODE1;
                else if (reload_ok)
                    state_d = LOAD;
            end
            MODE1:     state_d = MODE0;
            MODE0:     state_d = LOAD;
            LOAD:      if (beat_q == last_beat) state_d = START;
            START: begin
                o_core_start = 1'b1;
                state_d      = WAIT_CORE;
            end
            WAIT_CORE: if (i_core_done) state_d = SEND;
            SEND: begin
                o_data_valid = 1'b1;
                if (retire && (beat_q == last_beat))
                    state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= BITS16;
            beat_q    <= '0;
            loaded_q  <= 1'b0;
            reload_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= strobe && i_cmd && !loaded_q;
            if (strobe)
                reload_q <= i_cmd;
            if (state_q == MODE1)
                mode_q <= mode_e'({i_mode, mode_q[0]});
            if (state_q == MODE0)
                mode_q <= mode_e'({mode_q[1], i_mode});
            if ((state_q == LOAD) || retire)
                beat_q <= (beat_q == last_beat) ? '0 : beat_q + 1'b1;
            if ((state_q == LOAD) && (beat_q == last_beat))
                loaded_q <= 1'b1;
        end
    end

    assign o_cmd_err    = cmd_err_q;
    assign o_core_mode  = mode_q;
    assign o_core_a     = op_q[0];
    assign o_core_b     = op_q[1];
    assign o_core_prime = op_q[2];
    assign o_core_Px    = op_q[OP_PX];
    assign o_core_Py    = op_q[OP_PY];
    assign o_core_m     = op_q[5];
    assign o_Px = o_data_valid ? res_q[0][MAX_BITS-1 -: LANES] : '0;
    assign o_Py = o_data_valid ? res_q[1][MAX_BITS-1 -: LANES] : '0;

endmodule

// File: tb/tb_ecc_lane_port.sv
// Directed bench for ecc_lane_port: a LANES=1 and a LANES=4 instance share
// the control stimulus; each test checks only the instance it targets.
module tb_ecc_lane_port;

    logic clk = 1'b0;
    logic rst, dv, cmd, mode_bit, out_rdy, core_done;
    logic [3:0] la, lb, lp, lx, ly, lm;
    logic [127:0] rx, ry;

    logic dv1, px1, py1, busy1, err1, start1;
    logic [1:0] cmode1;
    logic [127:0] ca1, cb1, cp1, cx1, cy1, cm1;
    logic dv4, busy4, err4, start4;
    logic [3:0] px4, py4;
    logic [1:0] cmode4;
    logic [127:0] ca4, cb4, cp4, cx4, cy4, cm4;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, t_strobe = 0;
    int st_cnt1 = 0, st_cyc1 = 0, st_cnt4 = 0, st_cyc4 = 0, err_cnt1 = 0;
    int n1 = 0, n4 = 0, vcnt4 = 0;
    logic [127:0] s1x = '0, s1y = '0, s4x = '0, s4y = '0;

    always #5 clk = ~clk;

    ecc_lane_port #(.MAX_BITS(128), .LANES(1), .BEATW(7)) u_dut1 (
        .clk(clk), .rst(rst), .i_data_valid(dv), .i_cmd(cmd), .i_mode(mode_bit),
        .i_a(la[0]), .i_b(lb[0]), .i_prime(lp[0]), .i_Px(lx[0]), .i_Py(ly[0]), .i_m(lm[0]),
        .i_out_ready(out_rdy), .o_data_valid(dv1), .o_Px(px1), .o_Py(py1),
        .o_busy(busy1), .o_cmd_err(err1), .o_core_start(start1), .o_core_mode(cmode1),
        .o_core_a(ca1), .o_core_b(cb1), .o_core_prime(cp1), .o_core_Px(cx1),
        .o_core_Py(cy1), .o_core_m(cm1), .i_core_done(core_done),
        .i_core_Rx(rx), .i_core_Ry(ry));

    ecc_lane_port #(.MAX_BITS(128), .LANES(4), .BEATW(7)) u_dut4 (
        .clk(clk), .rst(rst), .i_data_valid(dv), .i_cmd(cmd), .i_mode(mode_bit),
        .i_a(la), .i_b(lb), .i_prime(lp), .i_Px(lx), .i_Py(ly), .i_m(lm),
        .i_out_ready(out_rdy), .o_data_valid(dv4), .o_Px(px4), .o_Py(py4),
        .o_busy(busy4), .o_cmd_err(err4), .o_core_start(start4), .o_core_mode(cmode4),
        .o_core_a(ca4), .o_core_b(cb4), .o_core_prime(cp4), .o_core_Px(cx4),
        .o_core_Py(cy4), .o_core_m(cm4), .i_core_done(core_done),
        .i_core_Rx(rx), .i_core_Ry(ry));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start1) begin st_cnt1 = st_cnt1 + 1; st_cyc1 = cyc; end
        if (start4) begin st_cnt4 = st_cnt4 + 1; st_cyc4 = cyc; end
        if (err1) err_cnt1 = err_cnt1 + 1;
        if (dv4) vcnt4 = vcnt4 + 1;
        if (dv1 && out_rdy) begin
            s1x = {s1x[126:0], px1}; s1y = {s1y[126:0], py1}; n1 = n1 + 1;
        end
        if (dv4 && out_rdy) begin
            s4x = {s4x[123:0], px4}; s4y = {s4y[123:0], py4}; n4 = n4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [3:0] lane_bits(input logic [127:0] v, input int w,
                                             input int lanes, input int i);
        logic [3:0] r = '0;
        for (int k = 0; k < lanes; k++) r[k] = v[w - lanes - i*lanes + k];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; dv = 1'b0; cmd = 1'b0; mode_bit = 1'b0; out_rdy = 1'b1;
        core_done = 1'b0; rx = '0; ry = '0;
        la = '0; lb = '0; lp = '0; lx = '0; ly = '0; lm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns in the cycle after the last data beat (the expected START cycle).
    task automatic send_frame(input bit rl, input logic [1:0] md, input int lanes,
                              input logic [127:0] a, input logic [127:0] b,
                              input logic [127:0] p, input logic [127:0] x,
                              input logic [127:0] y, input logic [127:0] m,
                              input int abort_at);
        int w, n;
        w = 16 << md;
        n = w / lanes;
        @(posedge clk); #1;
        dv = 1'b1; cmd = rl; t_strobe = cyc;
        if (!rl) begin
            @(posedge clk); #1; dv = 1'b0; mode_bit = md[1];
            @(posedge clk); #1; mode_bit = md[0];
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            dv = 1'b0; cmd = 1'b0; mode_bit = 1'b0;
            if (i == abort_at) begin
                la = '0; lb = '0; lp = '0; lx = '0; ly = '0; lm = '0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            la = lane_bits(a, w, lanes, i); lb = lane_bits(b, w, lanes, i);
            lp = lane_bits(p, w, lanes, i); lx = lane_bits(x, w, lanes, i);
            ly = lane_bits(y, w, lanes, i); lm = lane_bits(m, w, lanes, i);
        end
        @(posedge clk); #1;
        la = '0; lb = '0; lp = '0; lx = '0; ly = '0; lm = '0;
    endtask

    task automatic core_respond(input bit sel4, input logic [127:0] x,
                                input logic [127:0] y, input int dly);
        repeat (dly) @(posedge clk);
        #1 rx = x; ry = y; core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0; rx = '0; ry = '0;
        chk("first_valid_latency", sel4 ? dv4 : dv1, 1);
    endtask

    task automatic drain(input bit sel4, input bit toggle, input int n, input bit poke_last);
        bit ph = 1'b1;
        bit done = 1'b0;
        int k = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            dv = 1'b0;
            if (sel4 ? dv4 : dv1) begin
                out_rdy = toggle ? ph : 1'b1;
                ph = ~ph;
                if (poke_last && k == n - 1) begin dv = 1'b1; cmd = 1'b0; end
                if (out_rdy) k++;
            end else if (k >= n) begin
                done = 1'b1;
            end else begin
                out_rdy = 1'b1;
            end
            if (!done) begin @(posedge clk); #1; end
        end
        dv = 1'b0; out_rdy = 1'b1;
        chk("drain_ends_after_n", done, 1);
    endtask

    initial begin
        int e0, s0, b0, v0;
        logic bsy;
        do_reset();
        @(negedge clk);
        chk("rst_valid", dv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_start_err", {start1, err1}, 0);
        chk("rst_mode", cmode1, 0);
        chk("rst_ops", ca1 | cb1 | cp1 | cx1 | cy1 | cm1, 0);
        chk("rst_px", {px1, py1}, 0);

        // reload with nothing loaded is rejected
        e0 = err_cnt1; s0 = st_cnt1;
        @(posedge clk); #1 dv = 1'b1; cmd = 1'b1;
        @(posedge clk); #1 dv = 1'b0; cmd = 1'b0;
        bsy = 1'b0;
        repeat (6) begin @(negedge clk); bsy = bsy | busy1; end
        chk("early_reload_err", err_cnt1 - e0, 1);
        chk("early_reload_busy", bsy, 0);
        chk("early_reload_nostart", st_cnt1 - s0, 0);

        // LANES=1, mode 00 full load
        s0 = st_cnt1;
        send_frame(1'b0, 2'b00, 1, 'h3, 'h7, 'hFFF1, 'h1234, 'hABCD, 'h5, -1);
        repeat (2) @(posedge clk); #1;
        chk("t1_start_time", st_cyc1 - t_strobe, 19);
        chk("t1_start_count", st_cnt1 - s0, 1);
        chk("t1_mode", cmode1, 2'b00);
        chk("t1_a", ca1, 'h3);
        chk("t1_b", cb1, 'h7);
        chk("t1_prime", cp1, 'hFFF1);
        chk("t1_px", cx1, 'h1234);
        chk("t1_py", cy1, 'hABCD);
        chk("t1_m", cm1, 'h5);
        chk("t1_busy_wait", busy1, 1);
        b0 = n1;
        core_respond(1'b0, 'h1234, 'hABCD, 8);
        drain(1'b0, 1'b0, 16, 1'b0);
        chk("t1_beats", n1 - b0, 16);
        chk("t1_stream_x", s1x[15:0], 16'h1234);
        chk("t1_stream_y", s1y[15:0], 16'hABCD);
        chk("t1_idle", busy1, 0);

        // point reload keeps a/b/prime/m
        s0 = st_cnt1;
        send_frame(1'b1, 2'b00, 1, '0, '0, '0, 'h0F0F, 'h00FF, '0, -1);
        repeat (2) @(posedge clk); #1;
        chk("t2_start_time", st_cyc1 - t_strobe, 17);
        chk("t2_start_count", st_cnt1 - s0, 1);
        chk("t2_kept", {ca1[15:0], cb1[15:0], cp1[15:0], cm1[15:0]}, 64'h0003_0007_FFF1_0005);
        chk("t2_px", cx1, 'h0F0F);
        chk("t2_py", cy1, 'h00FF);
        b0 = n1;
        core_respond(1'b0, 'h0F0F, 'h00FF, 10);
        drain(1'b0, 1'b0, 16, 1'b0);
        chk("t2_beats", n1 - b0, 16);
        chk("t2_stream", {s1x[15:0], s1y[15:0]}, 32'h0F0F_00FF);

        // strobes during WAIT_CORE and on the final SEND beat are ignored
        s0 = st_cnt1;
        send_frame(1'b0, 2'b00, 1, 'h11, 'h22, 'h33, 'h5A5A, 'hA5A5, 'h44, -1);
        @(posedge clk); #1 dv = 1'b1; cmd = 1'b0;
        @(posedge clk); #1 dv = 1'b0;
        b0 = n1;
        core_respond(1'b0, 'h5A5A, 'hA5A5, 6);
        drain(1'b0, 1'b0, 16, 1'b1);
        repeat (6) @(posedge clk); #1;
        chk("t6_one_start", st_cnt1 - s0, 1);
        chk("t6_beats", n1 - b0, 16);
        chk("t6_stream", {s1x[15:0], s1y[15:0]}, 32'h5A5A_A5A5);
        chk("t6_idle", busy1, 0);

        // LANES=4, mode 11 with toggling back-pressure
        do_reset();
        s0 = st_cnt4;
        send_frame(1'b0, 2'b11, 4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                   128'h7, {{30{4'hF}}, 8'h61}, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666,
                   128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h3, -1);
        repeat (2) @(posedge clk); #1;
        chk("t3_start_time", st_cyc4 - t_strobe, 35);
        chk("t3_start_count", st_cnt4 - s0, 1);
        chk("t3_mode", cmode4, 2'b11);
        chk("t3_prime", cp4, {{30{4'hF}}, 8'h61});
        chk("t3_a", ca4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("t3_px", cx4, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
        b0 = n4; v0 = vcnt4;
        core_respond(1'b1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C,
                     128'h8000_0000_0000_0000_0000_0000_0000_0001, 5);
        drain(1'b1, 1'b1, 32, 1'b0);
        chk("t3_beats", n4 - b0, 32);
        chk("t3_valid_cycles", vcnt4 - v0, 63);
        chk("t3_stream_x", s4x, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
        chk("t3_stream_y", s4y, 128'h8000_0000_0000_0000_0000_0000_0000_0001);

        // reset at LOAD beat 5 of a mode-10 frame
        do_reset();
        send_frame(1'b0, 2'b10, 1, 'h1, 'h2, 'h3, 'h4, 'h5, 'h6, 5);
        @(negedge clk);
        chk("t5_outputs_zero", {dv1, busy1, err1, start1, px1, py1,
                                |(ca1 | cb1 | cp1 | cx1 | cy1 | cm1)}, 0);
        chk("t5_mode_zero", cmode1, 0);
        e0 = err_cnt1; s0 = st_cnt1;
        @(posedge clk); #1 dv = 1'b1; cmd = 1'b1;
        @(posedge clk); #1 dv = 1'b0; cmd = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("t5_reload_rejected", err_cnt1 - e0, 1);
        chk("t5_reload_nostart", st_cnt1 - s0, 0);
        s0 = st_cnt1;
        send_frame(1'b0, 2'b00, 1, 'h9, 'h8, 'hFFF1, 'hBEEF, 'h0001, 'h2, -1);
        repeat (2) @(posedge clk); #1;
        chk("t5_start_time", st_cyc1 - t_strobe, 19);
        chk("t5_start_count", st_cnt1 - s0, 1);
        chk("t5_px", cx1, 'hBEEF);
        b0 = n1;
        core_respond(1'b0, 'hBEEF, 'h0001, 10);
        drain(1'b0, 1'b0, 16, 1'b0);
        chk("t5_beats", n1 - b0, 16);
        chk("t5_stream", {s1x[15:0], s1y[15:0]}, 32'hBEEF_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
